// File: rtl/sw_rx_tag_demux.sv
// Tag demultiplexer: strips a 1-byte port tag from a GMII stream and routes the frame to one of four ports.
// Optional statistics counters are built only when SW_DEMUX_STAT_EN is defined.
//
// state    | meaning
// WAIT_GAP | after reset, waiting for a dv=0 cycle so a partial frame is discarded
// IDLE     | between frames; the next dv=1 byte is the tag
// FWD      | forwarding payload to the latched port
// DROP     | discarding the rest of a bad, disabled or truncated frame
module sw_rx_tag_demux #(
  parameter int C_MAX_LEN = 1536,
  parameter int C_CNT_W   = 16
) (
  input  logic                 I_125m_clk,
  input  logic                 I_rst,
  input  logic [3:0]           I_port_en,
  input  logic                 I_rx_gmii_dv,
  input  logic                 I_rx_gmii_err,
  input  logic [7:0]           I_rx_gmii_d,
  output logic                 O_rx_gmii_dv_p0,
  output logic                 O_rx_gmii_dv_p1,
  output logic                 O_rx_gmii_dv_p2,
  output logic                 O_rx_gmii_dv_p3,
  output logic [7:0]           O_rx_gmii_d_p0,
  output logic [7:0]           O_rx_gmii_d_p1,
  output logic [7:0]           O_rx_gmii_d_p2,
  output logic [7:0]           O_rx_gmii_d_p3,
  output logic                 O_rx_gmii_err_p0,
  output logic                 O_rx_gmii_err_p1,
  output logic                 O_rx_gmii_err_p2,
  output logic                 O_rx_gmii_err_p3,
  output logic                 O_bad_tag,
  output logic                 O_port_drop,
  output logic                 O_oversize,
  output logic [4*C_CNT_W-1:0] O_frm_cnt,
  output logic [C_CNT_W-1:0]   O_bad_cnt
);

  localparam int LEN_W = ($clog2(C_MAX_LEN + 1) > 11) ? $clog2(C_MAX_LEN + 1) : 11;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(C_MAX_LEN);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, FWD, DROP} state_t;

  state_t           state_q, state_n;
  logic             dv_r, err_r;
  logic [7:0]       d_r;
  logic [3:0]       en_r;
  logic [1:0]       port_q, port_n;
  logic [LEN_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             tag_ok, at_max;
  logic [3:0]       dv_n, err_n, dv_q, err_q;
  logic [3:0][7:0]  d_n, d_q;
  logic             bad_tag_n, port_drop_n, oversize_n;
  logic             bad_tag_q, port_drop_q, oversize_q;

  assign tag_ok  = (d_r[7:4] == 4'hA) && (d_r[3:2] == 2'b00) && !err_r;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
  assign at_max  = (cnt_inc == MAX_LEN);

  always_ff @(posedge I_125m_clk or posedge I_rst) begin
    if (I_rst) begin
      dv_r    <= 1'b0;
      err_r   <= 1'b0;
      d_r     <= '0;
      en_r    <= '0;
      state_q <= WAIT_GAP;
      port_q  <= '0;
      cnt_q   <= '0;
    end else begin
      dv_r    <= I_rx_gmii_dv;
      err_r   <= I_rx_gmii_err;
      d_r     <= I_rx_gmii_d;
      en_r    <= I_port_en;
      state_q <= state_n;
      port_q  <= port_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    port_n      = port_q;
    cnt_n       = cnt_q;
    dv_n        = '0;
    d_n         = '0;
    err_n       = '0;
    bad_tag_n   = 1'b0;
    port_drop_n = 1'b0;
    oversize_n  = 1'b0;
    unique case (state_q)
      // Raw input dv is used here: the input register reads 0 right after reset,
      // which would otherwise look like a gap in a frame still in flight.
      WAIT_GAP: if (!I_rx_gmii_dv) state_n = IDLE;
      IDLE: begin
        if (dv_r) begin
          cnt_n = '0;
          if (!tag_ok) begin
            state_n   = DROP;
            bad_tag_n = 1'b1;
          end else if (!en_r[d_r[1:0]]) begin
            state_n     = DROP;
            port_drop_n = 1'b1;
          end else begin
            state_n = FWD;
            port_n  = d_r[1:0];
          end
        end
      end
      FWD: begin
        if (!dv_r) begin
          state_n = IDLE;
        end else begin
          cnt_n         = cnt_inc;
          dv_n[port_q]  = 1'b1;
          d_n[port_q]   = d_r;
          err_n[port_q] = err_r | at_max;
          if (at_max) begin
            state_n    = DROP;
            oversize_n = 1'b1;
          end
        end
      end
      DROP: if (!dv_r) state_n = IDLE;
      default: state_n = WAIT_GAP;
    endcase
  end

  always_ff @(posedge I_125m_clk or posedge I_rst) begin
    if (I_rst) begin
      dv_q        <= '0;
      d_q         <= '0;
      err_q       <= '0;
      bad_tag_q   <= 1'b0;
      port_drop_q <= 1'b0;
      oversize_q  <= 1'b0;
    end else begin
      dv_q        <= dv_n;
      d_q         <= d_n;
      err_q       <= err_n;
      bad_tag_q   <= bad_tag_n;
      port_drop_q <= port_drop_n;
      oversize_q  <= oversize_n;
    end
  end

  assign O_rx_gmii_dv_p0  = dv_q[0];
  assign O_rx_gmii_dv_p1  = dv_q[1];
  assign O_rx_gmii_dv_p2  = dv_q[2];
  assign O_rx_gmii_dv_p3  = dv_q[3];
  assign O_rx_gmii_d_p0   = d_q[0];
  assign O_rx_gmii_d_p1   = d_q[1];
  assign O_rx_gmii_d_p2   = d_q[2];
  assign O_rx_gmii_d_p3   = d_q[3];
  assign O_rx_gmii_err_p0 = err_q[0];
  assign O_rx_gmii_err_p1 = err_q[1];
  assign O_rx_gmii_err_p2 = err_q[2];
  assign O_rx_gmii_err_p3 = err_q[3];
  assign O_bad_tag        = bad_tag_q;
  assign O_port_drop      = port_drop_q;
  assign O_oversize       = oversize_q;

`ifdef SW_DEMUX_STAT_EN
  logic [3:0][C_CNT_W-1:0] frm_cnt_q;
  logic [C_CNT_W-1:0]      bad_cnt_q;
  logic                    frm_done;

  // Truncated frames leave FWD through DROP, so they never count as good.
  assign frm_done = (state_q == FWD) && !dv_r;

  always_ff @(posedge I_125m_clk or posedge I_rst) begin
    if (I_rst) begin
      frm_cnt_q <= '0;
      bad_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (frm_done && (port_q == 2'(i)) && (frm_cnt_q[i] != '1))
          frm_cnt_q[i] <= frm_cnt_q[i] + C_CNT_W'(1);
      end
      if ((bad_tag_q || port_drop_q || oversize_q) && (bad_cnt_q != '1))
        bad_cnt_q <= bad_cnt_q + C_CNT_W'(1);
    end
  end

  assign O_frm_cnt = frm_cnt_q;
  assign O_bad_cnt = bad_cnt_q;
`else
  assign O_frm_cnt = '0;
  assign O_bad_cnt = '0;
`endif

endmodule

// File: tb/tb_sw_rx_tag_demux.sv
// Bench for sw_rx_tag_demux: two instances (default length limit and a 16-byte limit) share one stimulus;
// a per-instance event scoreboard checks every output byte, pulse and its cycle.
module tb_sw_rx_tag_demux;

  typedef struct packed {
    logic [3:0]  kind;   // 0 data, 1 bad tag, 2 port drop, 3 oversize
    logic [3:0]  port;
    logic [7:0]  d;
    logic        err;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] port_en = 4'hF;
  logic       dv = 1'b0, er = 1'b0;
  logic [7:0] d = '0;

  logic [3:0]  a_dv, a_err, b_dv, b_err;
  logic [7:0]  a_d [4];
  logic [7:0]  b_d [4];
  logic        a_bt, a_pd, a_ov, b_bt, b_pd, b_ov;
  logic [63:0] a_frm, b_frm;
  logic [15:0] a_bad, b_bad;

  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  ev_t  qa[$], qb[$];
  int   frm_m [2][4];
  int   bad_m [2];

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sw_rx_tag_demux dut_a (
    .I_125m_clk(clk), .I_rst(rst), .I_port_en(port_en),
    .I_rx_gmii_dv(dv), .I_rx_gmii_err(er), .I_rx_gmii_d(d),
    .O_rx_gmii_dv_p0(a_dv[0]), .O_rx_gmii_dv_p1(a_dv[1]),
    .O_rx_gmii_dv_p2(a_dv[2]), .O_rx_gmii_dv_p3(a_dv[3]),
    .O_rx_gmii_d_p0(a_d[0]), .O_rx_gmii_d_p1(a_d[1]),
    .O_rx_gmii_d_p2(a_d[2]), .O_rx_gmii_d_p3(a_d[3]),
    .O_rx_gmii_err_p0(a_err[0]), .O_rx_gmii_err_p1(a_err[1]),
    .O_rx_gmii_err_p2(a_err[2]), .O_rx_gmii_err_p3(a_err[3]),
    .O_bad_tag(a_bt), .O_port_drop(a_pd), .O_oversize(a_ov),
    .O_frm_cnt(a_frm), .O_bad_cnt(a_bad)
  );

  sw_rx_tag_demux #(.C_MAX_LEN(16)) dut_b (
    .I_125m_clk(clk), .I_rst(rst), .I_port_en(port_en),
    .I_rx_gmii_dv(dv), .I_rx_gmii_err(er), .I_rx_gmii_d(d),
    .O_rx_gmii_dv_p0(b_dv[0]), .O_rx_gmii_dv_p1(b_dv[1]),
    .O_rx_gmii_dv_p2(b_dv[2]), .O_rx_gmii_dv_p3(b_dv[3]),
    .O_rx_gmii_d_p0(b_d[0]), .O_rx_gmii_d_p1(b_d[1]),
    .O_rx_gmii_d_p2(b_d[2]), .O_rx_gmii_d_p3(b_d[3]),
    .O_rx_gmii_err_p0(b_err[0]), .O_rx_gmii_err_p1(b_err[1]),
    .O_rx_gmii_err_p2(b_err[2]), .O_rx_gmii_err_p3(b_err[3]),
    .O_bad_tag(b_bt), .O_port_drop(b_pd), .O_oversize(b_ov),
    .O_frm_cnt(b_frm), .O_bad_cnt(b_bad)
  );

  function automatic ev_t mk_ev(input int kind, input int port, input logic [7:0] dd,
                                input logic e, input int c);
    ev_t ev;
    ev.kind = 4'(kind);
    ev.port = 4'(port);
    ev.d    = dd;
    ev.err  = e;
    ev.cyc  = 32'(c);
    return ev;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input ev_t ev);
    if (k == 0) qa.push_back(ev);
    else qb.push_back(ev);
  endtask

  task automatic check_ev(input int k, input ev_t act);
    ev_t exp;
    exp = '1;
    if (k == 0 && qa.size() > 0) exp = qa.pop_front();
    if (k == 1 && qb.size() > 0) exp = qb.pop_front();
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL ev_inst%0d observed=%h expected=%h", k, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic [3:0] mdv, input logic [3:0] merr,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                     input logic [7:0] d3, input logic bt, input logic pd, input logic ov);
    logic [7:0] dd [4];
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    for (int p = 0; p < 4; p++) begin
      if (mdv[p]) check_ev(k, mk_ev(0, p, dd[p], merr[p], cyc));
      else chk("idle_port", {dd[p], merr[p]}, 64'd0);
    end
    if (bt) check_ev(k, mk_ev(1, 0, 8'd0, 1'b0, cyc));
    if (pd) check_ev(k, mk_ev(2, 0, 8'd0, 1'b0, cyc));
    if (ov) check_ev(k, mk_ev(3, 0, 8'd0, 1'b0, cyc));
  endtask

  always @(negedge clk) begin
    mon(0, a_dv, a_err, a_d[0], a_d[1], a_d[2], a_d[3], a_bt, a_pd, a_ov);
    mon(1, b_dv, b_err, b_d[0], b_d[1], b_d[2], b_d[3], b_bt, b_pd, b_ov);
  end

  // Drives tag + n payload bytes followed by a single dv=0 gap cycle and
  // pushes the expected events for both length limits.
  task automatic drive_frame(input logic [7:0] tag, input int n, input logic terr, input int err_at);
    logic [7:0] b;
    bit         valid, en;
    int         p0, mlen;
    valid = (tag[7:4] == 4'hA) && (tag[3:2] == 2'b00) && !terr;
    en    = port_en[tag[1:0]];
    @(negedge clk);
    dv = 1'b1; d = tag; er = terr; p0 = cyc;
    for (int k = 0; k < 2; k++) begin
      if (!valid) begin
        push(k, mk_ev(1, 0, 8'd0, 1'b0, p0 + 2));
        bad_m[k]++;
      end else if (!en) begin
        push(k, mk_ev(2, 0, 8'd0, 1'b0, p0 + 2));
        bad_m[k]++;
      end
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      b = 8'($urandom_range(0, 255));
      d = b; er = (i == err_at);
      if (valid && en) begin
        for (int k = 0; k < 2; k++) begin
          mlen = (k == 0) ? 1536 : 16;
          if (i <= mlen) push(k, mk_ev(0, tag[1:0], b, (i == err_at) || (i == mlen), cyc + 2));
          if (i == mlen) begin
            push(k, mk_ev(3, 0, 8'd0, 1'b0, cyc + 2));
            bad_m[k]++;
          end
        end
      end
    end
    if (valid && en) begin
      for (int k = 0; k < 2; k++) begin
        mlen = (k == 0) ? 1536 : 16;
        if (n < mlen) frm_m[k][tag[1:0]]++;
      end
    end
    @(negedge clk);
    dv = 1'b0; d = '0; er = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    chk({name, "_qa_empty"}, 64'(qa.size()), 64'd0);
    chk({name, "_qb_empty"}, 64'(qb.size()), 64'd0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      bad_m[k] = 0;
      for (int p = 0; p < 4; p++) frm_m[k][p] = 0;
    end
  endtask

  initial begin
    logic [7:0] b;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_dv", {b_dv, a_dv}, 64'd0);
    chk("rst_pulses", {a_bt, a_pd, a_ov, b_bt, b_pd, b_ov}, 64'd0);
    chk("rst_frm_cnt", a_frm, 64'd0);
    chk("rst_bad_cnt", 64'(a_bad), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    drive_frame(8'hA2, 64, 1'b0, 0);
    drain("port2_64");

    drive_frame(8'h53, 10, 1'b0, 0);
    drive_frame(8'hA0, 12, 1'b0, 0);
    drain("bad_tag");

    drive_frame(8'hA4, 3, 1'b0, 0);
    drive_frame(8'hA2, 3, 1'b1, 0);
    drain("tag_bits_err");

    port_en = 4'b1110;
    drive_frame(8'hA0, 5, 1'b0, 0);
    drive_frame(8'hA1, 7, 1'b0, 0);
    drain("port_drop");
    port_en = 4'hF;

    drive_frame(8'hA1, 20, 1'b0, 0);
    drive_frame(8'hA3, 6, 1'b0, 3);
    drain("oversize");

    drive_frame(8'hA0, 16, 1'b0, 0);
    drive_frame(8'hA1, 15, 1'b0, 0);
    drain("len_edge");

    // Reset asserted while byte 10 of a port 3 frame is on the input.
    @(negedge clk);
    dv = 1'b1; d = 8'hA3; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      b = 8'($urandom_range(0, 255));
      d = b;
      if (i <= 8) begin
        push(0, mk_ev(0, 3, b, 1'b0, cyc + 2));
        push(1, mk_ev(0, 3, b, 1'b0, cyc + 2));
      end
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_dv", {b_dv, a_dv}, 64'd0);
    chk("rst_mid_d3", {a_d[3], b_d[3], a_err, b_err}, 64'd0);
    clear_model();
    repeat (2) begin
      @(negedge clk);
      d = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst = 1'b0; d = 8'($urandom_range(0, 255));
    repeat (3) begin
      @(negedge clk);
      d = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    dv = 1'b0; d = '0;
    drive_frame(8'hA3, 8, 1'b0, 0);
    drain("rst_mid");

    drive_frame(8'hA1, 5, 1'b0, 0);
    drive_frame(8'hA1, 9, 1'b0, 0);
    drive_frame(8'hA1, 2, 1'b0, 0);
    drive_frame(8'h74, 4, 1'b0, 0);
    drain("stats");

`ifdef SW_DEMUX_STAT_EN
    for (int p = 0; p < 4; p++) begin
      chk("frm_cnt_a", 64'(a_frm[p*16 +: 16]), 64'(frm_m[0][p]));
      chk("frm_cnt_b", 64'(b_frm[p*16 +: 16]), 64'(frm_m[1][p]));
    end
    chk("bad_cnt_a", 64'(a_bad), 64'(bad_m[0]));
    chk("bad_cnt_b", 64'(b_bad), 64'(bad_m[1]));
`else
    chk("frm_cnt_off", a_frm | b_frm, 64'd0);
    chk("bad_cnt_off", 64'(a_bad | b_bad), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
